// File: rtl/hwpe_stream_fence_scheduler.sv
// Lockstep fence across NB_STREAMS HWPE-Stream lanes for one bounded command.
// Optional stall watchdog: define HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN.
module hwpe_stream_fence_scheduler #(
    parameter int unsigned NB_STREAMS     = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             test_mode_i,
    input  logic                             start_i,
    input  logic [NB_STREAMS-1:0]            mask_i,
    input  logic [CNT_WIDTH-1:0]             len_i,
    input  logic [NB_STREAMS-1:0]            push_valid_i,
    output logic [NB_STREAMS-1:0]            push_ready_o,
    input  logic [NB_STREAMS*DATA_WIDTH-1:0] push_data_i,
    input  logic [NB_STREAMS*STRB_WIDTH-1:0] push_strb_i,
    output logic [NB_STREAMS-1:0]            pop_valid_o,
    input  logic [NB_STREAMS-1:0]            pop_ready_i,
    output logic [NB_STREAMS*DATA_WIDTH-1:0] pop_data_o,
    output logic [NB_STREAMS*STRB_WIDTH-1:0] pop_strb_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             timeout_o,
    output logic [CNT_WIDTH-1:0]             beat_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FENCE,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [NB_STREAMS-1:0]   r_mask;
    logic [CNT_WIDTH-1:0]    r_len;
    logic [CNT_WIDTH-1:0]    r_beat_cnt;

    logic                    w_in_fence;
    logic                    w_all_v;
    logic                    w_all_r;
    logic                    w_fire;
    logic                    w_last;
    logic                    w_unused;

    assign w_unused   = test_mode_i | (TIMEOUT_CYCLES == 0);

    assign w_in_fence = (r_state == S_FENCE);
    assign w_all_v    = &(push_valid_i | ~r_mask);
    assign w_all_r    = &(pop_ready_i  | ~r_mask);
    assign w_fire     = w_in_fence & w_all_v & w_all_r;
    assign w_last     = (r_beat_cnt == r_len - 1'b1);

    // Disabled lanes stay blocked so their pending beats survive for a later command.
    assign pop_valid_o  = {NB_STREAMS{w_in_fence & w_all_v}} & r_mask;
    assign push_ready_o = {NB_STREAMS{w_fire}} & r_mask;
    assign pop_data_o   = push_data_i;
    assign pop_strb_o   = push_strb_i;

    assign busy_o     = w_in_fence;
    assign done_o     = (r_state == S_DONE);
    assign beat_cnt_o = r_beat_cnt;

`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] r_stall;
    logic [STALL_W-1:0] w_stall_nxt;
    logic               r_timeout;

    assign w_stall_nxt = r_stall + 1'b1;
    assign timeout_o   = done_o & r_timeout;
`else
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
            r_stall    <= '0;
            r_timeout  <= 1'b0;
`endif
        end else if (clear_i) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
            r_stall    <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mask     <= mask_i;
                        r_len      <= len_i;
                        r_beat_cnt <= '0;
`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
                        r_stall    <= '0;
                        r_timeout  <= 1'b0;
`endif
                        r_state    <= ((len_i == '0) || (mask_i == '0)) ? S_DONE : S_FENCE;
                    end
                end
                S_FENCE: begin
                    if (w_fire) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
                        r_stall    <= '0;
`endif
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
                    // Abort on the stall cycle that brings the counter to TIMEOUT_CYCLES-1.
                    else if (w_stall_nxt >= STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        r_stall   <= w_stall_nxt;
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_stall   <= w_stall_nxt;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_stream_fence_scheduler.sv
// Scoreboard bench for hwpe_stream_fence_scheduler: expected beats and done results are
// queued when a command is issued and popped by a negedge monitor.
module tb_hwpe_stream_fence_scheduler;

    localparam int NB = 2;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear, tmode, start;
    logic [NB-1:0]   mask;
    logic [CW-1:0]   len;
    logic [NB-1:0]   push_valid, push_ready, pop_valid, pop_ready;
    logic [NB*DW-1:0] push_data, pop_data;
    logic [NB*SW-1:0] push_strb, pop_strb;
    logic            busy, done, tout;
    logic [CW-1:0]   beat_cnt;

    always #5 clk = ~clk;

    hwpe_stream_fence_scheduler #(
        .NB_STREAMS    (NB),
        .DATA_WIDTH    (DW),
        .STRB_WIDTH    (SW),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .test_mode_i (tmode),
        .start_i     (start),
        .mask_i      (mask),
        .len_i       (len),
        .push_valid_i(push_valid),
        .push_ready_o(push_ready),
        .push_data_i (push_data),
        .push_strb_i (push_strb),
        .pop_valid_o (pop_valid),
        .pop_ready_i (pop_ready),
        .pop_data_o  (pop_data),
        .pop_strb_o  (pop_strb),
        .busy_o      (busy),
        .done_o      (done),
        .timeout_o   (tout),
        .beat_cnt_o  (beat_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [NB-1:0] src_en;
    logic [15:0]   src_cnt [NB];
    logic [NB-1:0] cur_mask;
    logic [35:0]   exp_q0[$];
    logic [35:0]   exp_q1[$];
    logic [16:0]   done_q[$];

    int cyc = 0;
    int last_fire_cyc = 0, done_cyc = 0;
    int n_fire = 0, n_done = 0, n_busy = 0;
    logic [NB-1:0] pv_acc, pr_acc;
    logic          m_av, m_f;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] beat(input int lane, input logic [15:0] c);
        logic [31:0] d;
        logic [3:0]  s;
        d = {8'hA0 + 8'(lane), 8'h5C, c};
        s = c[3:0] ^ 4'(lane);
        return {s, d};
    endfunction

    task automatic drive_src();
        logic [35:0] b;
        for (int i = 0; i < NB; i++) begin
            b = beat(i, src_cnt[i]);
            push_valid[i]           = src_en[i];
            push_data[i*DW +: DW]   = b[31:0];
            push_strb[i*SW +: SW]   = b[35:32];
        end
    endtask

    // One clock: lanes that were acknowledged at this edge present their next beat.
    task automatic tick();
        logic [NB-1:0] hs;
        @(negedge clk);
        hs = push_valid & push_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NB; i++) if (hs[i]) src_cnt[i] = src_cnt[i] + 16'd1;
        drive_src();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input logic [NB-1:0] m, input logic [CW-1:0] l);
        start    = 1'b1;
        mask     = m;
        len      = l;
        cur_mask = m;
        if (m != '0) begin
            for (int k = 0; k < int'(l); k++) begin
                if (m[0]) exp_q0.push_back(beat(0, src_cnt[0] + 16'(k)));
                if (m[1]) exp_q1.push_back(beat(1, src_cnt[1] + 16'(k)));
            end
        end
        tick();
        start = 1'b0;
        mask  = NB'($urandom);
        len   = CW'($urandom);
    endtask

    task automatic flush(input string tag, input int n);
        chk({tag, "_left0"}, 64'(exp_q0.size()), 64'(n));
        chk({tag, "_left1"}, 64'(exp_q1.size()), 64'(n));
        exp_q0.delete();
        exp_q1.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            m_av = busy & (&(push_valid | ~cur_mask));
            m_f  = m_av & (&(pop_ready | ~cur_mask));
            chk("pop_valid", 64'(pop_valid), m_av ? 64'(cur_mask) : 64'd0);
            chk("push_ready", 64'(push_ready), m_f ? 64'(cur_mask) : 64'd0);
            pv_acc = pv_acc | pop_valid;
            pr_acc = pr_acc | push_ready;
            if (busy) n_busy++;
            if (m_f) begin
                n_fire++;
                last_fire_cyc = cyc;
                if (cur_mask[0]) begin
                    chk("pop0_avail", 64'(exp_q0.size() != 0), 64'd1);
                    if (exp_q0.size() != 0)
                        chk("pop0_beat", {28'd0, pop_strb[3:0], pop_data[31:0]}, 64'(exp_q0.pop_front()));
                end
                if (cur_mask[1]) begin
                    chk("pop1_avail", 64'(exp_q1.size() != 0), 64'd1);
                    if (exp_q1.size() != 0)
                        chk("pop1_beat", {28'd0, pop_strb[7:4], pop_data[63:32]}, 64'(exp_q1.pop_front()));
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_avail", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0) chk("done_result", 64'({tout, beat_cnt}), 64'(done_q.pop_front()));
            end else begin
                chk("timeout_idle", 64'(tout), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, f0, d0;
        logic [15:0] s1;
        rst_n = 1'b0; clear = 1'b0; tmode = 1'b0; start = 1'b0;
        mask = '0; len = '0; pop_ready = 2'b11; src_en = 2'b11;
        cur_mask = '0; pv_acc = '0; pr_acc = '0;
        for (int i = 0; i < NB; i++) src_cnt[i] = 16'd0;
        drive_src();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state with all inputs asserted
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_timeout", 64'(tout), 0);
        chk("rst_pop_valid", 64'(pop_valid), 0);
        chk("rst_push_ready", 64'(push_ready), 0);
        chk("rst_beat_cnt", 64'(beat_cnt), 0);
        @(posedge clk);
        #1;

        // T1: full mask, len 4, always valid/ready
        b0 = n_busy; f0 = n_fire; d0 = n_done;
        done_q.push_back({1'b0, 16'd4});
        issue(2'b11, 16'd4);
        run(6);
        chk("t1_busy_cycles", 64'(n_busy - b0), 4);
        chk("t1_fires", 64'(n_fire - f0), 4);
        chk("t1_dones", 64'(n_done - d0), 1);
        chk("t1_done_latency", 64'(done_cyc - last_fire_cyc), 1);
        chk("t1_beat_hold", 64'(beat_cnt), 4);

        // T2: lane1 valid only from the fourth fence cycle
        src_en = 2'b01; drive_src();
        f0 = n_fire; d0 = n_done; pv_acc = '0; pr_acc = '0;
        done_q.push_back({1'b0, 16'd2});
        issue(2'b11, 16'd2);
        run(3);
        chk("t2_no_fire_early", 64'(n_fire - f0), 0);
        chk("t2_no_pop_valid", 64'(pv_acc), 0);
        chk("t2_no_push_ready", 64'(pr_acc), 0);
        chk("t2_still_busy", 64'(busy), 1);
        src_en = 2'b11; drive_src();
        run(5);
        chk("t2_fires", 64'(n_fire - f0), 2);
        chk("t2_dones", 64'(n_done - d0), 1);

        // T3: lane0 only; lane1 valid must stay pending
        f0 = n_fire; pv_acc = '0; pr_acc = '0; s1 = src_cnt[1];
        done_q.push_back({1'b0, 16'd2});
        issue(2'b01, 16'd2);
        run(5);
        chk("t3_lane1_pop_valid", 64'(pv_acc[1]), 0);
        chk("t3_lane1_push_ready", 64'(pr_acc[1]), 0);
        chk("t3_lane1_pending", 64'({push_valid[1], src_cnt[1]}), 64'({1'b1, s1}));
        chk("t3_fires", 64'(n_fire - f0), 2);

        // T4: zero length, then zero mask with start held through both DONE cycles
        b0 = n_busy; f0 = n_fire; d0 = n_done;
        done_q.push_back({1'b0, 16'd0});
        done_q.push_back({1'b0, 16'd0});
        issue(2'b11, 16'd0);
        start = 1'b1; mask = 2'b00; len = 16'd5; cur_mask = 2'b00;
        run(3);
        start = 1'b0;
        run(4);
        chk("t4_dones", 64'(n_done - d0), 2);
        chk("t4_no_fire", 64'(n_fire - f0), 0);
        chk("t4_no_busy", 64'(n_busy - b0), 0);
        chk("t4_beat_cnt", 64'(beat_cnt), 0);

        // T5: clear after 2 of 5 beats, then a normal len-3 command
        f0 = n_fire; d0 = n_done;
        issue(2'b11, 16'd5);
        run(2);
        pop_ready = 2'b00; clear = 1'b1;
        tick();
        clear = 1'b0; pop_ready = 2'b11;
        chk("t5_idle_after_clear", 64'(busy), 0);
        chk("t5_cnt_after_clear", 64'(beat_cnt), 0);
        chk("t5_fires_before_clear", 64'(n_fire - f0), 2);
        flush("t5", 3);
        run(2);
        chk("t5_no_done", 64'(n_done - d0), 0);
        f0 = n_fire;
        done_q.push_back({1'b0, 16'd3});
        issue(2'b11, 16'd3);
        run(6);
        chk("t5_restart_fires", 64'(n_fire - f0), 3);
        chk("t5_restart_dones", 64'(n_done - d0), 1);
        chk("t5_restart_cnt", 64'(beat_cnt), 3);

        // T6: one beat, then lane1 stalls
        f0 = n_fire; d0 = n_done;
`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
        done_q.push_back({1'b1, 16'd1});
`endif
        issue(2'b11, 16'd4);
        tick();
        src_en = 2'b01; drive_src();
`ifdef HWPE_STREAM_FENCE_SCHEDULER_TIMEOUT_EN
        run(12);
        chk("t6_dones", 64'(n_done - d0), 1);
        chk("t6_timeout_latency", 64'(done_cyc - last_fire_cyc), TO);
        chk("t6_fires", 64'(n_fire - f0), 1);
        chk("t6_beat_cnt", 64'(beat_cnt), 1);
`else
        run(20);
        chk("t6_still_busy", 64'(busy), 1);
        chk("t6_no_timeout", 64'(tout), 0);
        chk("t6_no_done", 64'(n_done - d0), 0);
        chk("t6_fires", 64'(n_fire - f0), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_cleared", 64'(busy), 0);
`endif
        flush("t6", 3);
        src_en = 2'b11; drive_src();
        run(2);

        chk("queues_drained", 64'(exp_q0.size() + exp_q1.size() + done_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
